imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory: fills the word-addressed instruction store before execution, replacing file preload for in-system program loading.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word through a single-cycle write strobe at consecutive word addresses, the same word indexing the PC uses for fetch.
- Holds the CPU in a stalled state until a load completes.

Parameters:
- ADDR_W, 16, word-address width; 2^ADDR_W words of instruction store.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  load request; sampled only in IDLE
- base_addr  input  ADDR_W  first word address, latched on accepted start
- word_count  input  ADDR_W+1  number of words to load, 0..2^ADDR_W, latched on accepted start
- in_valid  input  1  byte stream valid
- in_data  input  8  byte stream data
- in_ready  output  1  loader can accept a byte
- wr_en  output  1  instruction-store write strobe, one cycle per word
- wr_addr  output  ADDR_W  word address for the write
- wr_data  output  32  assembled instruction word
- busy  output  1  high outside IDLE
- done  output  1  one-cycle pulse when the load completes
- loaded_words  output  ADDR_W+1  words written since the last accepted start
- checksum  output  32  XOR of all words written since the last accepted start
- cpu_hold  output  1  stalls the fetch PC while high

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; in_ready, wr_en, busy, done=0; wr_addr, wr_data, loaded_words, checksum=0; byte index=0; cpu_hold=1. Any partial word is discarded and no write is issued.
- States are IDLE, RECV, WRITE and DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 and word_count=0: go to DONE and issue no writes.
  - start=1 and word_count>0: latch base_addr and word_count; clear loaded_words, checksum and byte index; set cpu_hold=1; go to RECV.
- RECV:
  - in_ready=1. A byte is accepted only in a cycle with in_valid=1 and in_ready=1.
  - Byte order: byte 0 goes to bits 31:24, byte 1 to 23:16, byte 2 to 15:8, byte 3 to 7:0.
  - in_valid low simply stalls; there is no timeout.
  - When the 4th byte is accepted, go to WRITE.
- WRITE (one cycle):
  - in_ready=0, wr_en=1, wr_addr=(base_addr+loaded_words) mod 2^ADDR_W, wr_data=assembled word.
  - In the same edge: loaded_words+1 and checksum^=wr_data.
  - If loaded_words+1 equals word_count go to DONE, else go to RECV with byte index 0.
- DONE (one cycle): done=1, cpu_hold=0, busy=1; then go to IDLE.
- Latency: start accepted at cycle t. With bytes offered back-to-back, the write of word k (k=1..N) is at t+5k. done is at t+5N+1.
- Address wrap: wr_addr wraps modulo 2^ADDR_W with no error flag.
- start while busy is ignored; latched parameters are unchanged.
- cpu_hold stays high from reset until the first done. It goes high again on each accepted start and low again at that load's done.
- Outside WRITE: wr_en=0, and wr_addr/wr_data hold their last values.
- Reset mid-load: the store keeps any words already written, cpu_hold=1, and the next start restarts from scratch.

Test Plan:
- Reset, then start with base_addr=0, word_count=2; bytes 20,11,00,05,8C,A2,00,04 sent back-to-back.
  -> write 0x20110005 at address 0 at t+5; write 0x8CA20004 at address 1 at t+10.
  -> done at t+11; checksum=0xACB30001; loaded_words=2; cpu_hold falls at t+11.
- Same load with in_valid low for 3 cycles between bytes 2 and 3.
  -> identical writes, each delayed by the stall; no byte lost or duplicated.
- base_addr=0xFFFF, word_count=2.
  -> writes to 0xFFFF then 0x0000.
- start with word_count=0.
  -> done one cycle later, no wr_en, cpu_hold=0.
- start pulsed during RECV with different base_addr.
  -> ignored; writes continue at the original addresses.
- rst_n low after 2 bytes of word 1.
  -> outputs at reset values immediately, no wr_en, cpu_hold=1; a following full load of 1 word writes correctly.

Source files
------------

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// Byte-stream loader for the instruction store: packs big-endian bytes into
// 32-bit words, writes them at consecutive word addresses, and stalls the CPU until done.
module imem_loader #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   loaded_words,
  output logic [31:0]       checksum,
  output logic              cpu_hold
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [1:0]        byte_idx;
  logic [23:0]       shift;
  logic              accept;
  logic              start_go;
  logic [ADDR_W:0]   words_next;

  assign accept     = in_valid & in_ready;
  assign start_go   = (state == IDLE) & start;
  assign words_next = loaded_words + {{ADDR_W{1'b0}}, 1'b1};

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (word_count == {(ADDR_W+1){1'b0}}) ? DONE : RECV;
        end else begin
          state_nx = IDLE;
        end
      end
      RECV: begin
        if (accept && (byte_idx == 2'd3)) begin
          state_nx = WRITE;
        end else begin
          state_nx = RECV;
        end
      end
      WRITE: begin
        if (words_next == count_q) begin
          state_nx = DONE;
        end else begin
          state_nx = RECV;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and registered outputs; outputs are decoded from the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      base_q       <= {ADDR_W{1'b0}};
      count_q      <= {(ADDR_W+1){1'b0}};
      byte_idx     <= 2'd0;
      shift        <= 24'd0;
      in_ready     <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= {ADDR_W{1'b0}};
      wr_data      <= 32'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      loaded_words <= {(ADDR_W+1){1'b0}};
      checksum     <= 32'd0;
      cpu_hold     <= 1'b1;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx == RECV);
      busy     <= (state_nx != IDLE);
      done     <= (state_nx == DONE);
      wr_en    <= (state_nx == WRITE);

      if (start_go) begin
        base_q       <= base_addr;
        count_q      <= word_count;
        loaded_words <= {(ADDR_W+1){1'b0}};
        checksum     <= 32'd0;
        byte_idx     <= 2'd0;
      end else if (state == WRITE) begin
        loaded_words <= words_next;
        checksum     <= checksum ^ wr_data;
      end else if ((state == RECV) && accept) begin
        shift    <= {shift[15:0], in_data};
        byte_idx <= byte_idx + 2'd1;
      end else begin
        shift <= shift;
      end

      // The 4th byte bypasses the shifter so the word is complete on entry to WRITE
      if ((state == RECV) && (state_nx == WRITE)) begin
        wr_addr <= base_q + loaded_words[ADDR_W-1:0];
        wr_data <= {shift, in_data};
      end else begin
        wr_addr <= wr_addr;
      end

      if (state_nx == DONE) begin
        cpu_hold <= 1'b0;
      end else if (start_go) begin
        cpu_hold <= 1'b1;
      end else begin
        cpu_hold <= cpu_hold;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// Bench for imem_loader: directed and randomized loads checked against a
// byte-list reference model (expected words, addresses, write cycles, checksum).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'd0;
  logic [16:0] word_count = 17'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, wr_en, busy, done, cpu_hold;
  logic [15:0] wr_addr;
  logic [31:0] wr_data, checksum;
  logic [16:0] loaded_words;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  logic [15:0] wq_a[$];
  logic [31:0] wq_d[$];
  int          wq_c[$];
  logic [7:0]  stim[$];
  int          acc[$];

  imem_loader #(.ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .loaded_words(loaded_words), .checksum(checksum),
    .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wq_a.push_back(wr_addr);
      wq_d.push_back(wr_data);
      wq_c.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wq_a.delete(); wq_d.delete(); wq_c.delete(); acc.delete();
    done_cnt = 0;
  endtask

  task automatic start_load(input logic [15:0] b, input logic [16:0] n);
    start = 1'b1; base_addr = b; word_count = n;
    @(negedge clk);
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 16'($urandom); word_count = 17'($urandom_range(0, 9));
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    in_valid = 1'b1; in_data = b;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        acc.push_back(cyc);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_data = 8'($urandom);
    chk("byte_accept", got, 1);
  endtask

  task automatic do_load(input string tag, input logic [15:0] base, input int n,
                         input int max_stall, input int stall_idx, input int stall_len,
                         input bit poke, input logic [15:0] poke_base);
    bit got = 1'b0;
    logic [31:0] w;
    logic [31:0] cs = 32'd0;
    clear_log();
    start_load(base, 17'(n));
    chk({tag, "_hold"}, cpu_hold, 1);
    chk({tag, "_busy"}, busy, 1);
    for (int i = 0; i < 4*n; i++) begin
      int st = (i == stall_idx) ? stall_len : $urandom_range(0, max_stall);
      for (int s = 0; s < st; s++) begin
        in_valid = 1'b0; in_data = 8'($urandom);
        @(posedge clk); #1;
      end
      send_byte(stim[i]);
      if (poke && i == 0) begin
        start = 1'b1; base_addr = poke_base; word_count = 17'd3;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1; done_cyc = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_nwrites"}, wq_a.size(), n);
    for (int k = 0; k < n; k++) begin
      w = {stim[4*k], stim[4*k+1], stim[4*k+2], stim[4*k+3]};
      cs ^= w;
      if (k < wq_a.size()) begin
        chk({tag, "_addr"}, wq_a[k], 16'(base + k));
        chk({tag, "_data"}, wq_d[k], w);
        chk({tag, "_wcyc"}, wq_c[k], acc[4*k+3] + 1);
      end
    end
    if (wq_c.size() > 0) chk({tag, "_done_cyc"}, done_cyc, wq_c[wq_c.size()-1] + 1);
    chk({tag, "_checksum"}, checksum, cs);
    chk({tag, "_loaded"}, loaded_words, n);
    chk({tag, "_hold_done"}, cpu_hold, 0);
    chk({tag, "_busy_done"}, busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_hold"}, cpu_hold, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_loaded", loaded_words, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_hold", cpu_hold, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk); #1;
    chk("hold_before_load", cpu_hold, 1);

    // Basic two-word load with exact latency
    stim = '{8'h20, 8'h11, 8'h00, 8'h05, 8'h8C, 8'hA2, 8'h00, 8'h04};
    do_load("basic", 16'h0000, 2, 0, -1, 0, 1'b0, 16'h0);
    if (wq_c.size() == 2) begin
      chk("basic_lat_w1", wq_c[0], t0 + 5);
      chk("basic_lat_w2", wq_c[1], t0 + 10);
    end
    chk("basic_lat_done", done_cyc, t0 + 11);
    chk("basic_cs_const", checksum, 32'hACB30001);

    // Same load with a 3-cycle in_valid gap before the third byte
    do_load("stall", 16'h0000, 2, 0, 2, 3, 1'b0, 16'h0);
    if (wq_c.size() == 2) begin
      chk("stall_lat_w1", wq_c[0], t0 + 8);
      chk("stall_lat_w2", wq_c[1], t0 + 13);
    end
    chk("stall_lat_done", done_cyc, t0 + 14);

    // Address wrap
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
    do_load("wrap", 16'hFFFF, 2, 1, -1, 0, 1'b0, 16'h0);
    if (wq_a.size() == 2) begin
      chk("wrap_a0", wq_a[0], 16'hFFFF);
      chk("wrap_a1", wq_a[1], 16'h0000);
    end

    // Zero-word load
    clear_log();
    start_load(16'h1234, 17'd0);
    @(negedge clk);
    chk("zero_done_cyc", cyc, t0 + 1);
    chk("zero_done", done, 1);
    chk("zero_hold", cpu_hold, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_nwrites", wq_a.size(), 0);
    chk("zero_busy", busy, 0);
    @(posedge clk); #1;

    // start during RECV must be ignored
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
    do_load("poke", 16'h0100, 2, 1, -1, 0, 1'b1, 16'h0F00);

    // Reset in the middle of a load
    clear_log();
    start_load(16'h0200, 17'd1);
    send_byte(8'hDE);
    send_byte(8'hAD);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_hold", cpu_hold, 1);
    chk("mid_rst_loaded", loaded_words, 0);
    @(negedge clk);
    chk("mid_rst_nwrites", wq_a.size(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    stim = '{8'hBE, 8'hEF, 8'h12, 8'h34};
    do_load("after_rst", 16'h0300, 1, 0, -1, 0, 1'b0, 16'h0);

    // Randomized loads
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, 4);
      stim.delete();
      for (int i = 0; i < 4*n; i++) stim.push_back(8'($urandom));
      do_load("rand", 16'($urandom), n, 2, -1, 0, 1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
